easyaxi_rd_slv: RTL and testbench

AXI read responder (slave) that terminates the AR/R channels driven by the team's outstanding-capable read master.
- Accepts up to OST_DEPTH outstanding AR requests into an in-order command queue.
- Generates per-beat addresses for FIXED, INCR and WRAP bursts.
- Returns deterministic address-pattern read data with RLAST and RRESP, after a programmable access latency.
- Serves as the bench-side memory model and as the template for real read slaves.

---
 rtl/easyaxi_rd_slv.sv | 218 +++++++++++++++++++++
 tb/tb_easyaxi_rd_slv.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easyaxi_rd_slv.sv
// AXI read responder: in-order AR queue, FIXED/INCR/WRAP beat addressing,
// address-pattern read data with programmable first-beat latency.
module easyaxi_rd_slv #(
    parameter int OST_DEPTH   = 4,
    parameter int RD_LAT      = 2,
    parameter int MEM_BYTES   = 256,
    parameter int AXI_ID_W    = 4,
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_LEN_W   = 8,
    parameter int AXI_SIZE_W  = 3,
    parameter int AXI_BURST_W = 2,
    parameter int AXI_USER_W  = 4,
    parameter int AXI_DATA_W  = 32,
    parameter int AXI_RESP_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         axi_slv_arvalid,
    output logic                         axi_slv_arready,
    input  logic [AXI_ID_W-1:0]          axi_slv_arid,
    input  logic [AXI_ADDR_W-1:0]        axi_slv_araddr,
    input  logic [AXI_LEN_W-1:0]         axi_slv_arlen,
    input  logic [AXI_SIZE_W-1:0]        axi_slv_arsize,
    input  logic [AXI_BURST_W-1:0]       axi_slv_arburst,
    input  logic [AXI_USER_W-1:0]        axi_slv_aruser,
    output logic                         axi_slv_rvalid,
    input  logic                         axi_slv_rready,
    output logic [AXI_ID_W-1:0]          axi_slv_rid,
    output logic [AXI_DATA_W-1:0]        axi_slv_rdata,
    output logic [AXI_RESP_W-1:0]        axi_slv_rresp,
    output logic                         axi_slv_rlast,
    output logic [AXI_USER_W-1:0]        axi_slv_ruser,
    output logic [$clog2(OST_DEPTH):0]   ost_cnt
);

    localparam int CW = $clog2(OST_DEPTH) + 1;
    localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int WW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    localparam logic [AXI_BURST_W-1:0] B_FIXED = AXI_BURST_W'(0);
    localparam logic [AXI_BURST_W-1:0] B_INCR  = AXI_BURST_W'(1);
    localparam logic [AXI_BURST_W-1:0] B_WRAP  = AXI_BURST_W'(2);
    localparam logic [AXI_BURST_W-1:0] B_RSVD  = AXI_BURST_W'(3);

    localparam logic [AXI_RESP_W-1:0] R_OKAY   = AXI_RESP_W'(0);
    localparam logic [AXI_RESP_W-1:0] R_SLVERR = AXI_RESP_W'(2);
    localparam logic [AXI_RESP_W-1:0] R_DECERR = AXI_RESP_W'(3);

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [AXI_USER_W-1:0]  user;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(OST_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic f_err(input cmd_t c);
        logic w_len_ok;
        w_len_ok = (c.len == AXI_LEN_W'(1)) || (c.len == AXI_LEN_W'(3)) ||
                   (c.len == AXI_LEN_W'(7)) || (c.len == AXI_LEN_W'(15));
        return (c.burst == B_RSVD) || (c.burst == B_WRAP && !w_len_ok);
    endfunction

    cmd_t                   r_q [OST_DEPTH];
    logic [PW-1:0]          r_wp;
    logic [PW-1:0]          r_rp;
    logic [CW-1:0]          r_cnt;

    state_t                 r_state;
    logic [AXI_ID_W-1:0]    r_id;
    logic [AXI_ADDR_W-1:0]  r_addr;
    logic [AXI_LEN_W-1:0]   r_len;
    logic [AXI_SIZE_W-1:0]  r_size;
    logic [AXI_BURST_W-1:0] r_burst;
    logic [AXI_USER_W-1:0]  r_user;
    logic                   r_err;
    logic [AXI_LEN_W-1:0]   r_beat;
    logic [WW-1:0]          r_wait;

    cmd_t                   w_ar;
    cmd_t                   w_cmd;
    logic                   w_avail;
    logic                   w_load;
    logic                   w_push;
    logic                   w_rhs;
    logic                   w_last;
    logic                   w_pop;
    logic [AXI_ADDR_W-1:0]  w_b;
    logic [AXI_ADDR_W-1:0]  w_mask;
    logic [AXI_ADDR_W-1:0]  w_incr;
    logic [AXI_ADDR_W-1:0]  w_wrap;
    logic [AXI_ADDR_W-1:0]  w_next;

    assign w_ar = '{id: axi_slv_arid, addr: axi_slv_araddr,
                    len: axi_slv_arlen, size: axi_slv_arsize,
                    burst: axi_slv_arburst, user: axi_slv_aruser};

    assign axi_slv_arready = (r_cnt != CW'(OST_DEPTH));
    assign axi_slv_rvalid  = (r_state == DATA);
    assign axi_slv_rlast   = axi_slv_rvalid && w_last;
    assign axi_slv_rid     = r_id;
    assign axi_slv_ruser   = r_user;
    assign axi_slv_rdata   = AXI_DATA_W'(r_addr);
    assign axi_slv_rresp   = r_err ? R_SLVERR :
                             (r_addr >= AXI_ADDR_W'(MEM_BYTES)) ? R_DECERR :
                             R_OKAY;
    assign ost_cnt = r_cnt;

    assign w_push = axi_slv_arvalid && axi_slv_arready;
    assign w_rhs  = axi_slv_rvalid && axi_slv_rready;
    assign w_last = (r_beat == r_len);
    assign w_pop  = w_rhs && w_last;

    // An AR accepted this cycle is bypassed straight into the engine when
    // nothing older is waiting, so an idle slave loses no cycle.
    always_comb begin
        w_avail = 1'b0;
        w_cmd   = w_ar;
        if (r_state == DATA) begin
            w_avail = (r_cnt > CW'(1)) || w_push;
            if (r_cnt > CW'(1)) w_cmd = r_q[f_inc(r_rp)];
        end else begin
            w_avail = (r_cnt != '0) || w_push;
            if (r_cnt != '0) w_cmd = r_q[r_rp];
        end
    end

    assign w_load = ((r_state == IDLE) && w_avail) ||
                    ((r_state == DATA) && w_pop && w_avail);

    assign w_b    = AXI_ADDR_W'(1) << r_size;
    assign w_mask = ((AXI_ADDR_W'(r_len) + AXI_ADDR_W'(1)) << r_size)
                    - AXI_ADDR_W'(1);
    assign w_incr = (r_addr & ~(w_b - AXI_ADDR_W'(1))) + w_b;
    assign w_wrap = (r_addr & ~w_mask) | ((r_addr + w_b) & w_mask);

    always_comb begin
        w_next = w_incr;
        unique case (1'b1)
            (!r_err && r_burst == B_FIXED): w_next = r_addr;
            (!r_err && r_burst == B_WRAP):  w_next = w_wrap;
            default:                        w_next = w_incr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wp] <= w_ar;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= f_inc(r_wp);
            if (w_pop)  r_rp <= f_inc(r_rp);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_user  <= '0;
            r_err   <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
        end else if (w_load) begin
            r_id    <= w_cmd.id;
            r_addr  <= w_cmd.addr;
            r_len   <= w_cmd.len;
            r_size  <= w_cmd.size;
            r_burst <= w_cmd.burst;
            r_user  <= w_cmd.user;
            r_err   <= f_err(w_cmd);
            r_beat  <= '0;
            r_wait  <= WW'(RD_LAT);
            r_state <= (RD_LAT == 0) ? DATA : WAIT;
        end else begin
            unique case (r_state)
                IDLE: ;
                WAIT: begin
                    r_wait <= r_wait - WW'(1);
                    if (r_wait == WW'(1)) r_state <= DATA;
                end
                DATA: begin
                    if (w_rhs) begin
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr <= w_next;
                            r_beat <= r_beat + AXI_LEN_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Directed bench for easyaxi_rd_slv: vector table of single bursts plus
// outstanding-fill, backpressure and mid-burst reset sequences.
module tb_easyaxi_rd_slv;

    logic        clk;
    logic        rst_n;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  aruser;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  ruser;
    logic [2:0]  ost_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    easyaxi_rd_slv dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arsize  (arsize),
        .axi_slv_arburst (arburst),
        .axi_slv_aruser  (aruser),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_rlast   (rlast),
        .axi_slv_ruser   (ruser),
        .ost_cnt         (ost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [3:0][31:0]  dat;
        logic [3:0][1:0]   rsp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] a,
                            input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b);
        arvalid = 1'b1;
        arid    = id;
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        aruser  = id ^ 4'hA;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic ar_send(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n;
        n = 0;
        drive_ar(id, a, l, s, b);
        while (!arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ar_accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(output int k);
        k = 0;
        while (!rvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        int   k;
        logic [3:0] id;
        t  = vecs[v];
        id = 4'(v);
        ar_send(id, t.addr, t.len, t.size, t.burst);
        wait_rvalid(k);
        chk($sformatf("v%0d_latency", v), k, 2);
        for (int b = 0; b <= int'(t.len); b++) begin
            chk($sformatf("v%0d_b%0d_rvalid", v, b), rvalid, 1);
            chk($sformatf("v%0d_b%0d_rdata", v, b), rdata, t.dat[b]);
            chk($sformatf("v%0d_b%0d_rresp", v, b), rresp, t.rsp[b]);
            chk($sformatf("v%0d_b%0d_rlast", v, b), rlast,
                (b == int'(t.len)) ? 1 : 0);
            chk($sformatf("v%0d_b%0d_rid", v, b), rid, id);
            chk($sformatf("v%0d_b%0d_ruser", v, b), ruser, id ^ 4'hA);
            @(negedge clk);
        end
        chk($sformatf("v%0d_end_rvalid", v), rvalid, 0);
        chk($sformatf("v%0d_end_ost", v), ost_cnt, 0);
    endtask

    int          got;
    int          idx;
    int          t_last0;
    int          t_ar5;
    int          t_first1;
    logic [3:0]  rec_id   [10];
    logic [31:0] rec_data [10];
    logic        rec_last [10];
    int          k;
    int          hs;
    int          pat [8];
    logic        prev_rdy;
    logic [31:0] prev_data;
    logic        prev_last;

    initial begin
        vecs[0] = '{addr: 32'h00, len: 8'd3, size: 3'd2, burst: 2'b01,
                    dat: {32'h0C, 32'h08, 32'h04, 32'h00},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{addr: 32'h34, len: 8'd3, size: 3'd2, burst: 2'b10,
                    dat: {32'h30, 32'h3C, 32'h38, 32'h34},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[2] = '{addr: 32'h30, len: 8'd3, size: 3'd2, burst: 2'b00,
                    dat: {32'h30, 32'h30, 32'h30, 32'h30},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[3] = '{addr: 32'hF8, len: 8'd3, size: 3'd2, burst: 2'b01,
                    dat: {32'h104, 32'h100, 32'hFC, 32'hF8},
                    rsp: {2'd3, 2'd3, 2'd0, 2'd0}};
        vecs[4] = '{addr: 32'h10, len: 8'd1, size: 3'd2, burst: 2'b11,
                    dat: {32'h0, 32'h0, 32'h14, 32'h10},
                    rsp: {2'd0, 2'd0, 2'd2, 2'd2}};
        vecs[5] = '{addr: 32'h20, len: 8'd2, size: 3'd2, burst: 2'b10,
                    dat: {32'h0, 32'h28, 32'h24, 32'h20},
                    rsp: {2'd0, 2'd2, 2'd2, 2'd2}};
        vecs[6] = '{addr: 32'h1C, len: 8'd1, size: 3'd2, burst: 2'b10,
                    dat: {32'h0, 32'h0, 32'h18, 32'h1C},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[7] = '{addr: 32'h41, len: 8'd1, size: 3'd2, burst: 2'b01,
                    dat: {32'h0, 32'h0, 32'h44, 32'h41},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[8] = '{addr: 32'h05, len: 8'd2, size: 3'd0, burst: 2'b01,
                    dat: {32'h0, 32'h07, 32'h06, 32'h05},
                    rsp: {2'd0, 2'd0, 2'd0, 2'd0}};

        rst_n   = 1'b0;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        aruser  = '0;
        rready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_ost", ost_cnt, 0);
        chk("rst_rdata", rdata, 0);

        for (int v = 0; v < 9; v++) run_vec(v);

        // Outstanding fill with R stalled, then drain in order.
        rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_ar(4'(i), 32'(i * 16), 8'd1, 3'd2, 2'b01);
            chk($sformatf("fill%0d_arready", i), arready, 1);
            @(negedge clk);
        end
        drive_ar(4'd4, 32'h40, 8'd1, 3'd2, 2'b01);
        chk("fill_full_arready", arready, 0);
        chk("fill_full_ost", ost_cnt, 4);
        repeat (3) @(negedge clk);
        chk("fill_hold_arready", arready, 0);
        chk("fill_hold_rvalid", rvalid, 1);
        rready   = 1'b1;
        got      = 0;
        idx      = 0;
        t_last0  = -1;
        t_ar5    = -1;
        t_first1 = -1;
        while (got < 10 && idx < 200) begin
            if (arvalid && arready && t_ar5 < 0) t_ar5 = idx;
            if (rvalid && rready) begin
                rec_id[got]   = rid;
                rec_data[got] = rdata;
                rec_last[got] = rlast;
                if (got == 1) t_last0 = idx;
                if (got == 2) t_first1 = idx;
                got++;
            end
            @(negedge clk);
            idx++;
            if (t_ar5 >= 0 && t_ar5 == idx - 1) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        chk("drain_beats", got, 10);
        chk("drain_ar5_time", t_ar5, t_last0 + 1);
        chk("drain_b2b_lat", t_first1, t_last0 + 3);
        for (int g = 0; g < got; g++) begin
            chk($sformatf("drain%0d_rid", g), rec_id[g], g / 2);
            chk($sformatf("drain%0d_rdata", g), rec_data[g],
                (g / 2) * 16 + (g % 2) * 4);
            chk($sformatf("drain%0d_rlast", g), rec_last[g], g % 2);
        end
        chk("drain_end_ost", ost_cnt, 0);
        chk("drain_end_rvalid", rvalid, 0);

        // Backpressure 1-0-0-1 mid-burst.
        pat = '{1, 0, 0, 1, 1, 1, 1, 1};
        ar_send(4'd9, 32'h40, 8'd3, 3'd2, 2'b01);
        wait_rvalid(k);
        chk("bp_latency", k, 2);
        hs        = 0;
        prev_rdy  = 1'b1;
        prev_data = '0;
        prev_last = 1'b0;
        for (int s = 0; s < 8 && hs < 4; s++) begin
            rready = pat[s][0];
            if (!prev_rdy) begin
                chk($sformatf("bp_s%0d_rvalid", s), rvalid, 1);
                chk($sformatf("bp_s%0d_hold_data", s), rdata, prev_data);
                chk($sformatf("bp_s%0d_hold_last", s), rlast, prev_last);
            end
            if (rvalid && rready) begin
                chk($sformatf("bp_hs%0d_rdata", hs), rdata, 32'h40 + hs * 4);
                chk($sformatf("bp_hs%0d_rlast", hs), rlast, (hs == 3) ? 1 : 0);
                hs++;
            end
            prev_rdy  = rready;
            prev_data = rdata;
            prev_last = rlast;
            @(negedge clk);
        end
        rready = 1'b1;
        chk("bp_beats", hs, 4);
        chk("bp_end_rvalid", rvalid, 0);

        // Reset in the middle of a burst.
        ar_send(4'd10, 32'h00, 8'd3, 3'd2, 2'b01);
        wait_rvalid(k);
        @(negedge clk);
        chk("mid_beat1_rdata", rdata, 32'h04);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rlast", rlast, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_rid", rid, 0);
        chk("mid_rst_ruser", ruser, 0);
        chk("mid_rst_rresp", rresp, 0);
        chk("mid_rst_ost", ost_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_ost", ost_cnt, 0);
        chk("post_rst_rvalid", rvalid, 0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
